mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the single-port synchronous memory_block: requester 0 = CPU core, requester 1 = loader/DMA.
- Round-robin arbitration, one accepted transfer per cycle, registered memory command, registered read return.
- Bus lock lets a requester hold the memory across a 6502 read-modify-write sequence, with a watchdog that forcibly releases a stuck lock.

Parameters:
DATA_WIDTH, 8, data width of the memory and both requesters
ADDR_WIDTH, 16, address width
LOCK_MAX, 16, max consecutive cycles a lock may be held before forced release (>=2)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous, active-low reset
r0_req  input  1  requester 0 transfer request; held with r0_we/r0_addr/r0_wdata stable until r0_gnt
r0_we  input  1  1 = write, 0 = read
r0_lock  input  1  request bus lock, sampled on transfer
r0_addr  input  ADDR_WIDTH  transfer address
r0_wdata  input  DATA_WIDTH  write data
r0_gnt  output  1  combinational grant; transfer occurs when r0_req & r0_gnt
r0_rvalid  output  1  one-cycle pulse: r0_rdata valid
r0_rdata  output  DATA_WIDTH  read data, registered, held until next r0_rvalid
r1_req, r1_we, r1_lock, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata  same as r0_*, for requester 1
mem_rd_enable  output  1  registered read strobe to memory_block
mem_wr_enable  output  1  registered write strobe to memory_block
mem_addr  output  ADDR_WIDTH  registered memory address
mem_wr_data  output  DATA_WIDTH  registered memory write data
mem_rd_data  input  DATA_WIDTH  memory read data, valid one cycle after mem_rd_enable
lock_err  output  1  one-cycle pulse on forced lock release

Behaviour:
- Reset (resetn low, async): all outputs 0, rdata registers 0, state FREE, rr pointer = 1 (requester 0 wins first tie), lock counter 0, in-flight reads discarded (no rvalid after reset).
- Lock state machine (FREE, LOCK0, LOCK1) and grant:
  - FREE: only one req -> grant it. Both req -> grant the requester != rr pointer. Pointer updates to the granted index on every transfer.
  - LOCKi: only requester i may be granted; other requester's gnt = 0 regardless of req.
  - Transfer by i with lock_i=1: next state LOCKi. Transfer by i with lock_i=0: next state FREE.
- gnt is combinational from req, state and pointer. Never both gnt high. gnt never asserted without the matching req.
- Pipeline, transfer in cycle T:
  - T+1: mem_addr/mem_wr_data registered. mem_wr_enable=we, mem_rd_enable=~we, one-cycle strobes. Strobes 0 in cycles with no transfer; addr/data hold their last value.
  - Write commits at the end of T+1; no write response.
  - Read: mem_rd_data valid in T+2, captured into rX_rdata. rX_rvalid pulses in T+3 for the originating requester only.
  - Read latency = 3 cycles from transfer, fully pipelined, in-order.
  - Write at T then read of the same address at T+1 returns the new data.
- Lock watchdog: counter clears on entering LOCKi. It increments each cycle in LOCKi with no transfer by i. At LOCK_MAX: force FREE, pulse lock_err in the next cycle, pointer = i (other requester wins next tie), counter cleared. Any transfer by i clears the counter.
- Requester deasserting req while ungranted is legal. Deasserting after gnt in the same cycle is not allowed (transfer already occurred).
- Widths: no arithmetic on addr/data. Counter width = clog2(LOCK_MAX+1).

Test Plan:
- Single read: r0 reads 0x1234 (mem preloaded 0xA5) -> r0_gnt same cycle, mem_rd_enable=1 and mem_addr=0x1234 at T+1, r0_rvalid pulse with r0_rdata=0xA5 at T+3. r1_rvalid stays 0.
- Round-robin: r0 and r1 both request reads continuously after reset -> grants alternate 0,1,0,1. One transfer per cycle. rvalids alternate in the same order 3 cycles later.
- Write-then-read: r1 writes 0x5A to 0x0200 at T, reads 0x0200 at T+1 -> mem_wr_enable at T+1, mem_rd_enable at T+2, r1_rdata=0x5A with r1_rvalid at T+4.
- Lock RMW: r0 reads 0x0010 with lock=1, r1 requesting continuously -> r1_gnt=0 until r0 writes 0x0010 with lock=0. r1 is granted the following cycle.
- Lock timeout: r0 transfers with lock=1 then idles, LOCK_MAX=16 -> after 16 idle cycles lock_err pulses once, state FREE, r1 granted next cycle. A tie then goes to r1.
- Async reset mid-read: assert resetn=0 at T+1 after an r0 read transfer -> all outputs 0 immediately. No r0_rvalid after release. First post-reset tie is granted to r0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter in front of a single-port
// synchronous memory. Requester 0 is the CPU core, requester 1 is the loader/DMA.
// A requester can lock the bus across a read-modify-write sequence. A watchdog
// forces a stuck lock free after LOCK_MAX idle cycles.
//
// Ports
//   clk, resetn           clock (rising edge), async active-low reset
//   rX_req/we/lock/addr/wdata   request from requester X; held until rX_gnt
//   rX_gnt                combinational grant; a transfer is rX_req & rX_gnt
//   rX_rvalid/rX_rdata    read return, 3 cycles after the transfer
//   mem_*                 registered command to memory; mem_rd_data returns
//                         one cycle after mem_rd_enable
//   lock_err              one-cycle pulse when the watchdog breaks a lock
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int LOCK_MAX   = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic                  r0_lock,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic                  r1_lock,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_rd_enable,
  output logic                  mem_wr_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  lock_err
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {FREE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_e;

  typedef struct packed {
    logic                  we;
    logic                  lock;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  req_t [1:0] rq;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       xfer;
  logic       sel;
  req_t       cur;

  state_e  state_q, state_d;
  logic    rr_q, rr_d;           // index of the last granted requester
  logic [CW-1:0] cnt_q, cnt_d;
  logic    lock_err_q, lock_err_d;

  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  // read tracking: [0] = strobe cycle, [1] = memory data cycle, [2] = return
  logic [2:0]            vld_pipe;
  logic [2:0]            src_pipe;
  logic [1:0][DATA_WIDTH-1:0] rdata_q;

  assign rq[0] = {r0_we, r0_lock, r0_addr, r0_wdata};
  assign rq[1] = {r1_we, r1_lock, r1_addr, r1_wdata};
  assign req   = {r1_req, r0_req};

  always_comb begin
    gnt = '0;
    case (state_q)
      FREE:    gnt = (req == 2'b11) ? (rr_q ? 2'b01 : 2'b10) : req;
      LOCK0:   gnt = {1'b0, req[0]};
      LOCK1:   gnt = {req[1], 1'b0};
      default: gnt = '0;
    endcase
    // keep every output low while reset is held
    if (!resetn) gnt = '0;
  end

  assign xfer = |gnt;
  assign sel  = gnt[1];
  assign cur  = rq[sel];

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    lock_err_d = 1'b0;
    if (xfer) begin
      // in a locked state only the owner can transfer, so this covers both
      rr_d    = sel;
      cnt_d   = '0;
      state_d = cur.lock ? (sel ? LOCK1 : LOCK0) : FREE;
    end else if (state_q != FREE) begin
      if (cnt_q == CW'(LOCK_MAX - 1)) begin
        // this idle cycle is the LOCK_MAX-th: break the lock and hand the
        // next tie to the other requester
        state_d    = FREE;
        cnt_d      = '0;
        lock_err_d = 1'b1;
        rr_d       = (state_q == LOCK1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= FREE;
      rr_q       <= 1'b1;
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      vld_pipe   <= '0;
      src_pipe   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      lock_err_q <= lock_err_d;
      wr_q       <= xfer & cur.we;
      if (xfer) begin
        addr_q  <= cur.addr;
        wdata_q <= cur.wdata;
      end
      vld_pipe <= {vld_pipe[1:0], xfer & ~cur.we};
      src_pipe <= {src_pipe[1:0], sel};
      if (vld_pipe[1]) rdata_q[src_pipe[1]] <= mem_rd_data;
    end
  end

  assign r0_gnt        = gnt[0];
  assign r1_gnt        = gnt[1];
  assign mem_rd_enable = vld_pipe[0];
  assign mem_wr_enable = wr_q;
  assign mem_addr      = addr_q;
  assign mem_wr_data   = wdata_q;
  assign r0_rvalid     = vld_pipe[2] & ~src_pipe[2];
  assign r1_rvalid     = vld_pipe[2] &  src_pipe[2];
  assign r0_rdata      = rdata_q[0];
  assign r1_rdata      = rdata_q[1];
  assign lock_err      = lock_err_q;
endmodule
